// File: rtl/tt_um_top_module_ka_pkg.sv
// Shared constants for the programmable 7-segment counter tile:
// pin field positions, prescaler width and the segment lookup.
package tt_um_top_module_ka_pkg;

    localparam int PRESCALE_W = 24;

    localparam int UI_RUN     = 0;
    localparam int UI_DIR     = 1;
    localparam int UI_HEX     = 2;
    localparam int UI_LOAD    = 3;
    localparam int UI_VAL_LSB = 4;

    localparam logic [4:0] MAX_EXP = 5'd24;

    // Entry n holds the active-high g..a pattern for digit n
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       run;
        logic       dir;
        logic       hex;
        logic       load;
        logic [3:0] val;
    } ctrl_t;

endpackage

// File: rtl/tt_um_top_module_ka_seg7_decoder.sv
// Combinational 4-bit digit to active-high 7-segment pattern.
module seg7_decoder
    import tt_um_top_module_ka_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[digit];

endmodule

// File: rtl/tt_um_top_module_ka.sv
// Single-digit up/down hex/decimal counter with power-of-two prescaler,
// loadable from the pins, driving a 7-segment display plus wrap flag.
module tt_um_top_module_ka
    import tt_um_top_module_ka_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    ctrl_t                 ctrl;
    logic [3:0]            digit, digit_nxt, load_val;
    logic [PRESCALE_W-1:0] p, p_nxt, term;
    logic                  dp, dp_nxt;
    logic [4:0]            exp_e;
    logic                  tick;
    logic [6:0]            seg;
    logic                  unused_uio;

    assign ctrl = '{run:  ui_in[UI_RUN],
                    dir:  ui_in[UI_DIR],
                    hex:  ui_in[UI_HEX],
                    load: ui_in[UI_LOAD],
                    val:  ui_in[UI_VAL_LSB +: 4]};

    assign unused_uio = &{1'b0, uio_in[7:5]};

    // Exponent clamps at the prescaler width; the shift then yields all ones
    assign exp_e = (uio_in[4:0] > MAX_EXP) ? MAX_EXP : uio_in[4:0];
    assign term  = ~({PRESCALE_W{1'b1}} << exp_e);

    // >= rather than == so lowering K mid-count never strands p above term
    assign tick     = ctrl.run && (p >= term);
    assign load_val = (!ctrl.hex && ctrl.val > 4'd9) ? 4'd9 : ctrl.val;

    always_comb begin
        digit_nxt = digit;
        p_nxt     = p;
        dp_nxt    = dp;
        if (ctrl.load) begin
            digit_nxt = load_val;
            p_nxt     = '0;
        end else if (!ctrl.run) begin
            p_nxt = '0;
        end else if (tick) begin
            p_nxt = '0;
            if (ctrl.dir) begin
                if (ctrl.hex ? (digit == 4'hF) : (digit >= 4'd9)) begin
                    digit_nxt = 4'd0;
                    dp_nxt    = ~dp;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_nxt = ctrl.hex ? 4'hF : 4'd9;
                    dp_nxt    = ~dp;
                end else if (!ctrl.hex && digit > 4'd9) begin
                    digit_nxt = 4'd9;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end
        end else begin
            p_nxt = p + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
            p     <= '0;
            dp    <= 1'b0;
        end else if (ena) begin
            digit <= digit_nxt;
            p     <= p_nxt;
            dp    <= dp_nxt;
        end
    end

    seg7_decoder u_dec (
        .digit (digit),
        .seg   (seg)
    );

    assign uo_out  = {dp, seg};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_top_module_ka.sv
// Bench for the 7-segment counter tile: constant vector tables plus a
// behavioural model feeding a scoreboard queue for the timing sequences.
module tb_tt_um_top_module_ka;

    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       ena, clk, rst_n;

    tt_um_top_module_ka dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         failures = 0;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int    m_digit = 0;
    longint m_p = 0;
    bit    m_dp = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model_uo();
        return {m_dp, seg_ref[m_digit]};
    endfunction

    task automatic model_step(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        int     e;
        longint t;
        int     v;
        if (!en) return;
        e = (int'(uio[4:0]) > 24) ? 24 : int'(uio[4:0]);
        t = (longint'(1) << e) - 1;
        if (ui[3]) begin
            v = int'(ui[7:4]);
            m_digit = (!ui[2] && v > 9) ? 9 : v;
            m_p = 0;
        end else if (!ui[0]) begin
            m_p = 0;
        end else if (m_p >= t) begin
            m_p = 0;
            if (ui[1]) begin
                if ((ui[2] && m_digit == 15) || (!ui[2] && m_digit >= 9)) begin
                    m_digit = 0; m_dp = !m_dp;
                end else m_digit++;
            end else begin
                if (m_digit == 0) begin
                    m_digit = ui[2] ? 15 : 9; m_dp = !m_dp;
                end else if (!ui[2] && m_digit > 9) m_digit = 9;
                else m_digit--;
            end
        end else begin
            m_p++;
        end
    endtask

    // Drive one enabled/disabled cycle; expected value queued at drive time
    task automatic cyc(input logic [7:0] ui, input logic [7:0] uio, input logic en, input string nm);
        logic [7:0] exp;
        ui_in = ui; uio_in = uio; ena = en;
        model_step(ui, uio, en);
        sb.push_back(model_uo());
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty got %02h expected entry", nm, uo_out);
        end else begin
            exp = sb.pop_front();
            check(nm, uo_out, exp);
        end
    endtask

    initial begin
        int first_one, first_two;
        logic [7:0] hex_seq[16] = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F,
                                    8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'hBF};
        logic [7:0] dec_seq[10] = '{8'hFF, 8'h87, 8'hFD, 8'hED, 8'hE6, 8'hCF, 8'hDB, 8'h86,
                                    8'hBF, 8'h6F};

        for (int i = 0; i < 16; i++)
            vecs.push_back('{ui: 8'h07, uio: 8'h00, exp: hex_seq[i], nm: $sformatf("hex_up_%0d", i)});
        vecs.push_back('{ui: 8'hC8, uio: 8'h00, exp: 8'hEF, nm: "dec_load_sat"});
        for (int i = 0; i < 10; i++)
            vecs.push_back('{ui: 8'h01, uio: 8'h00, exp: dec_seq[i], nm: $sformatf("dec_down_%0d", i)});

        ui_in = 8'hFF; uio_in = 8'h00; ena = 1'b1; rst_n = 1'b0;
        #2;
        check("reset_uo", uo_out, 8'h3F);
        check("reset_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        @(posedge clk); #1;
        check("reset_held_uo", uo_out, 8'h3F);
        @(negedge clk);
        ui_in = 8'h00; rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            cyc(vecs[i].ui, vecs[i].uio, 1'b1, {vecs[i].nm, "_model"});
            check(vecs[i].nm, uo_out, vecs[i].exp);
        end

        // K=3: first tick on the 8th enabled edge, second on the 16th
        cyc(8'h08, 8'h03, 1'b1, "k3_load0");
        first_one = -1; first_two = -1;
        for (int i = 1; i <= 16; i++) begin
            cyc(8'h07, 8'h03, 1'b1, $sformatf("k3_run_%0d", i));
            if (first_one < 0 && uo_out[6:0] == 7'h06) first_one = i;
            if (first_two < 0 && uo_out[6:0] == 7'h5B) first_two = i;
        end
        check("k3_first_tick_edge", 8'(first_one), 8'd8);
        check("k3_second_tick_edge", 8'(first_two), 8'd16);

        // ena low mid-count preserves phase
        cyc(8'h08, 8'h03, 1'b1, "ena_load0");
        for (int i = 0; i < 3; i++) cyc(8'h07, 8'h03, 1'b1, "ena_pre");
        for (int i = 0; i < 5; i++) cyc(8'h07, 8'h03, 1'b0, "ena_frozen");
        check("ena_frozen_seg", {1'b0, uo_out[6:0]}, 8'h3F);
        for (int i = 0; i < 4; i++) cyc(8'h07, 8'h03, 1'b1, "ena_post");
        check("ena_no_early_tick", {1'b0, uo_out[6:0]}, 8'h3F);
        cyc(8'h07, 8'h03, 1'b1, "ena_tick");
        check("ena_tick_seg", {1'b0, uo_out[6:0]}, 8'h06);

        // Load on the cycle a tick is due: load wins
        cyc(8'h08, 8'h02, 1'b1, "pri_load0");
        for (int i = 0; i < 3; i++) cyc(8'h07, 8'h02, 1'b1, "pri_run");
        cyc(8'h5F, 8'h02, 1'b1, "pri_load5");
        check("pri_load5_seg", {1'b0, uo_out[6:0]}, 8'h6D);

        // K=30 clamps to 24: no tick in a short window
        cyc(8'h08, 8'h1E, 1'b1, "k30_load0");
        for (int i = 0; i < 300; i++) cyc(8'h07, 8'h1E, 1'b1, "k30_run");
        check("k30_no_tick", {1'b0, uo_out[6:0]}, 8'h3F);

        // Async reset at digit 7 clears before the next edge
        cyc(8'h68, 8'h00, 1'b1, "ar_load6");
        cyc(8'h07, 8'h00, 1'b1, "ar_to7");
        check("ar_at7", {1'b0, uo_out[6:0]}, 8'h07);
        rst_n = 1'b0;
        #1;
        check("ar_cleared", uo_out, 8'h3F);
        m_digit = 0; m_p = 0; m_dp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h07, 8'h00, 1'b1, "ar_resume");
        check("ar_resume_seg", uo_out, 8'h06);
        check("tie_oe", uio_oe, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_top_module_ka.md
# tt_um_top_module_ka

Single-digit programmable counter with a 7-segment display driver, packaged as a TinyTapeout user tile. A power-of-two prescaler generates count ticks; the digit counts up or down in hex or decimal and can be loaded from the pins. The digit is decoded to active-high segments on `uo_out[6:0]`, and a wrap indicator drives `uo_out[7]`. The bidirectional pins are used as inputs only.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: tile enable; when low, all state holds.
- `ui_in` input 8:
  - [0] RUN
  - [1] DIR (1 = up, 0 = down)
  - [2] HEX (1 = wrap at F, 0 = decimal, wrap at 9)
  - [3] LOAD
  - [7:4] load value
- `uio_in` input 8: [4:0] prescale exponent K; [7:5] ignored.
- `uo_out` output 8: [6:0] segments g..a (bit0 = a, active-high); [7] wrap-toggle flag (DP).
- `uio_out` output 8: constant 0.
- `uio_oe` output 8: constant 0 (all uio pins are inputs).

## Operation
- State:
  - 4-bit `digit`
  - 24-bit prescaler `p`
  - 1-bit `dp`
- Effective exponent: E = min(K, 24). Terminal count T = 2^E − 1.
- Priority each enabled cycle (`ena` = 1): LOAD, then RUN, then hold.
- LOAD = 1:
  - `digit` ← `ui_in[7:4]`.
  - In decimal mode, values above 9 saturate to 9.
  - `p` ← 0. `dp` unchanged.
- RUN = 0 (and no LOAD): `p` ← 0, `digit` holds.
- RUN = 1 (and no LOAD):
  - If p ≥ T: a tick occurs and `p` ← 0. Using ≥ handles K decreasing mid-count.
  - Otherwise `p` ← p + 1.
- On a tick, up (DIR = 1):
  - Hex: F → 0 is a wrap.
  - Decimal: 9 → 0 is a wrap; any digit above 9 → 0 is also a wrap.
  - Otherwise `digit` + 1.
- On a tick, down (DIR = 0):
  - Hex: 0 → F is a wrap.
  - Decimal: 0 → 9 is a wrap; any digit above 9 → 9 with no wrap.
  - Otherwise `digit` − 1.
- On a wrap, `dp` toggles.
- `ena` = 0: `digit`, `p` and `dp` all hold.
- Segment decode (combinational from `digit`), in uo_out[6:0] hex:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- The HEX bit affects only counting and load saturation, never the decode.

## Timing
- Reset (asynchronous assert): `digit` = 0, `p` = 0, `dp` = 0.
- Outputs during reset: `uo_out` = 0x3F, `uio_out` = 0, `uio_oe` = 0.
- Segments follow `digit` combinationally; there is no pipeline stage.
  - A tick or load at edge n is visible on `uo_out` right after edge n.
- Tick period with RUN held is 2^E cycles.
  - With E = 0, a tick occurs on every enabled cycle.
  - After RUN rises or after a load, the first tick lands on the 2^E-th enabled edge.
- LOAD and a tick due in the same cycle: the load wins and the tick is dropped.
- Reset asserted mid-count clears state immediately. Counting resumes on the first edge after `rst_n` rises.
- The `ena` low interval freezes `p`, so the tick phase is preserved across it.

## Structure
- Shared package `tt_um_top_module_ka_pkg` holds:
  - The 16-entry segment lookup constant.
  - `ui_in` bit-index constants (RUN, DIR, HEX, LOAD, load field).
  - The prescaler width (24).
- Sub-module `seg7_decoder`: 4-bit digit in, 7-bit segments out, purely combinational.
- The top module holds the prescaler, the counter/wrap logic and the output tie-offs.

## Test plan
- Reset: hold `rst_n` low with any inputs -> `uo_out` = 0x3F, `uio_oe` = 0x00.
- Hex up count, wrap and DP:
  - Stimulus: K = 0, ui_in = 0x07 (RUN, up, hex), 16 cycles.
  - Segments step through 06, 5B, … 71, then 3F.
  - `uo_out[7]` becomes 1 on the F→0 edge.
- Decimal down count and load saturation:
  - Load 0xC with HEX = 0 -> segments 6F (digit 9).
  - RUN, down, K = 0: 9→0, then 0→9 with the DP toggling.
- Prescaler:
  - K = 3, RUN from digit 0 -> digit 1 after exactly 8 enabled edges, digit 2 after 16.
  - K = 30 behaves as K = 24 (no tick within 2^24 − 1 cycles).
- Enable and priority:
  - `ena` = 0 for 5 cycles mid-count -> no change in digit or phase.
  - LOAD = 1 together with a due tick, load value 0x5 -> segments 6D, no tick applied.
- Async reset mid-count at digit 7 -> `uo_out` = 0x3F before the next clock edge.
